branch_sequencer: RTL

Multi-cycle control FSM that sequences the RISC core around the branch/PC datapath. It owns the program counter and the latched condition flags, and handshakes with instruction and data memory. It strobes IR load, register write-back and link write, and resolves every branch from decoder fields and the flags latched at the last flag-setting instruction. It sits between the instruction decoder, the ALU flag outputs, the register file and both memory ports.

---
 rtl/branch_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer owning the pc and condition flags
module branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic [1:0]  branch,
  input  logic [5:0]  function_code,
  input  logic        is_mem,
  input  logic        is_halt,
  input  logic        flags_we,
  input  logic        negative,
  input  logic        zero,
  input  logic        carry,
  input  logic [31:0] reg1_value,
  input  logic [31:0] branch_address,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic        reg_we,
  output logic        link_we,
  output logic [31:0] link_value,
  output logic [2:0]  state,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_flag_n;
  logic        r_flag_z;
  logic        r_flag_c;
  // Low for the first cycle after reset release so imem_req only rises once
  // reset has been sampled inactive by a clock edge.
  logic        r_started;

  logic [31:0] w_pc_inc;
  logic        w_taken;
  logic [31:0] w_target;
  logic [31:0] w_branch_pc;
  logic        w_imem_req;

  assign w_pc_inc    = r_pc + 32'd1;
  assign w_branch_pc = w_taken ? w_target : w_pc_inc;
  assign w_imem_req  = (r_state == S_FETCH) && r_started;

  // Branch resolution from decoder class/function and the latched flags.
  always_comb begin
    w_taken  = 1'b0;
    w_target = branch_address;
    case (branch)
      2'b01: begin
        case (function_code)
          6'd0: begin
            w_taken  = 1'b1;
            w_target = reg1_value;
          end
          6'd1:    w_taken = r_flag_n;
          6'd2:    w_taken = r_flag_z;
          6'd3:    w_taken = !r_flag_z;
          default: w_taken = 1'b0;
        endcase
      end
      2'b10: begin
        case (function_code)
          6'd0:    w_taken = 1'b1;
          6'd1:    w_taken = r_flag_c;
          6'd2:    w_taken = !r_flag_c;
          default: w_taken = 1'b0;
        endcase
      end
      2'b11:   w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  // Sequencer: state, pc and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_flag_n  <= 1'b0;
      r_flag_z  <= 1'b0;
      r_flag_c  <= 1'b0;
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
      case (r_state)
        S_FETCH: begin
          if (r_started && imem_ready) begin
            r_state <= S_DECODE;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          if (is_halt) begin
            r_state <= S_HALT;
          end else if (branch != 2'b00) begin
            r_pc    <= w_branch_pc;
            r_state <= S_FETCH;
          end else begin
            // Only non-branch, non-halt instructions may update flags.
            if (flags_we) begin
              r_flag_n <= negative;
              r_flag_z <= zero;
              r_flag_c <= carry;
            end
            r_state <= is_mem ? S_MEM : S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_pc    <= w_pc_inc;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Strobes decode the registered state; ir_load also needs the ready of the
  // same cycle so a zero-wait fetch completes in its first cycle.
  assign pc         = r_pc;
  assign state      = r_state;
  assign imem_req   = w_imem_req;
  assign ir_load    = w_imem_req && imem_ready;
  assign dmem_req   = (r_state == S_MEM);
  assign reg_we     = (r_state == S_WB);
  assign link_we    = (r_state == S_EXEC) && !is_halt && (branch == 2'b11);
  assign link_value = w_pc_inc;
  assign halted     = (r_state == S_HALT);

endmodule
